// File: rtl/group_scoreboard_pkg.sv
// Shared constants and helpers for the group register-dependency scoreboard.
// Defaults describe the vanilla RV32 register file.
package group_scoreboard_pkg;

    localparam int RV32_reg_els_gp = 32;
    localparam int group_els_gp    = 4;

    // Width of an index or count; never collapses to zero bits.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/group_scoreboard_if.sv
// ID/EXE/writeback-side signal bundle of the group scoreboard.
// The master modport is the pipeline side; the slave modport is the scoreboard.
interface group_scoreboard_if
    import group_scoreboard_pkg::*;
#(
    parameter int els_p            = RV32_reg_els_gp,
    parameter int num_src_port_p   = 2,
    parameter int num_clear_port_p = 1
) ();

    localparam int id_width_lp  = safe_clog2(els_p);
    localparam int cnt_width_lp = safe_clog2(els_p + 1);

    // No ready signals: op_reads_rf_i, op_writes_rf_i, score_i and clear_i are
    // single-cycle valid qualifiers that the scoreboard always accepts; the
    // only back-pressure is dependency_o, which stalls the ID-stage op.
    logic [num_src_port_p-1:0][id_width_lp-1:0]   src_id_i;
    logic [num_src_port_p-1:0]                    src_group_i;
    logic [num_src_port_p-1:0]                    op_reads_rf_i;
    logic [id_width_lp-1:0]                       dest_id_i;
    logic                                         dest_group_i;
    logic                                         op_writes_rf_i;
    logic                                         score_i;
    logic [id_width_lp-1:0]                       score_id_i;
    logic                                         score_group_i;
    logic [num_clear_port_p-1:0]                  clear_i;
    logic [num_clear_port_p-1:0][id_width_lp-1:0] clear_id_i;
    logic                                         dependency_o;
    logic [cnt_width_lp-1:0]                      pending_count_o;
    logic                                         empty_o;

    modport master (
        output src_id_i, src_group_i, op_reads_rf_i,
        output dest_id_i, dest_group_i, op_writes_rf_i,
        output score_i, score_id_i, score_group_i,
        output clear_i, clear_id_i,
        input  dependency_o, pending_count_o, empty_o
    );

    modport slave (
        input  src_id_i, src_group_i, op_reads_rf_i,
        input  dest_id_i, dest_group_i, op_writes_rf_i,
        input  score_i, score_id_i, score_group_i,
        input  clear_i, clear_id_i,
        output dependency_o, pending_count_o, empty_o
    );

endinterface

// File: rtl/group_scoreboard_mask.sv
// Expands a base register id into a one-hot (scalar) or group_els_p-wide (group)
// register mask; groups wrap modulo els_p and need not be aligned.
module group_scoreboard_mask
    import group_scoreboard_pkg::*;
#(
    parameter int els_p       = RV32_reg_els_gp,
    parameter int group_els_p = group_els_gp,
    parameter bit drop_x0_p   = 1'b0,
    localparam int id_width_lp = safe_clog2(els_p)
) (
    input  logic [id_width_lp-1:0] i_base_id,
    input  logic                   i_group,
    input  logic                   i_v,
    output logic [els_p-1:0]       o_mask
);

    logic [els_p-1:0] w_mask;

    always_comb begin
        logic [id_width_lp-1:0] v_idx;
        w_mask = '0;
        v_idx  = '0;
        for (int k = 0; k < group_els_p; k++) begin
            // els_p is a power of two, so the id-width add wraps the group for free.
            v_idx = i_base_id + id_width_lp'(k);
            if (i_v && ((k == 0) || i_group)) begin
                w_mask[v_idx] = 1'b1;
            end
        end
        if (drop_x0_p) begin
            w_mask[0] = 1'b0;
        end
    end

    assign o_mask = w_mask;

endmodule

// File: rtl/group_scoreboard.sv
// Register-dependency scoreboard: one pending-write bit per register, scalar or
// group score/read masks, N clear ports, and an outstanding-write count for fences.
module group_scoreboard
    import group_scoreboard_pkg::*;
#(
    parameter int els_p             = RV32_reg_els_gp,
    parameter int num_src_port_p    = 2,
    parameter int num_clear_port_p  = 1,
    parameter int group_els_p       = group_els_gp,
    parameter bit x0_tied_to_zero_p = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    group_scoreboard_if.slave sb
);

    localparam int id_width_lp  = safe_clog2(els_p);
    localparam int cnt_width_lp = safe_clog2(els_p + 1);

    logic [els_p-1:0]                      r_sb;
    logic [els_p-1:0]                      w_sb_next;
    logic [num_src_port_p-1:0][els_p-1:0]  w_src_mask;
    logic [els_p-1:0]                      w_dest_mask;
    logic [els_p-1:0]                      w_rw_mask;
    logic [els_p-1:0]                      w_score_mask_raw;
    logic [els_p-1:0]                      w_score_mask;
    logic [els_p-1:0]                      w_clear_comb;
    logic                                  w_sb_hit;
    logic                                  w_score_overlap;
    logic                                  w_score_hit;
    logic [cnt_width_lp-1:0]               w_count;

    for (genvar g = 0; g < num_src_port_p; g++) begin : g_src_mask
        group_scoreboard_mask #(
            .els_p       (els_p),
            .group_els_p (group_els_p),
            .drop_x0_p   (1'b0)
        ) u_src_mask (
            .i_base_id (sb.src_id_i[g]),
            .i_group   (sb.src_group_i[g]),
            .i_v       (sb.op_reads_rf_i[g]),
            .o_mask    (w_src_mask[g])
        );
    end

    group_scoreboard_mask #(
        .els_p       (els_p),
        .group_els_p (group_els_p),
        .drop_x0_p   (1'b0)
    ) u_dest_mask (
        .i_base_id (sb.dest_id_i),
        .i_group   (sb.dest_group_i),
        .i_v       (sb.op_writes_rf_i),
        .o_mask    (w_dest_mask)
    );

    // Score mask is built unqualified so the late score_i only gates the final terms.
    group_scoreboard_mask #(
        .els_p       (els_p),
        .group_els_p (group_els_p),
        .drop_x0_p   (x0_tied_to_zero_p)
    ) u_score_mask (
        .i_base_id (sb.score_id_i),
        .i_group   (sb.score_group_i),
        .i_v       (1'b1),
        .o_mask    (w_score_mask_raw)
    );

    assign w_score_mask = sb.score_i ? w_score_mask_raw : '0;

    always_comb begin
        w_rw_mask = w_dest_mask;
        for (int p = 0; p < num_src_port_p; p++) begin
            w_rw_mask = w_rw_mask | w_src_mask[p];
        end
    end

    always_comb begin
        w_clear_comb = '0;
        for (int p = 0; p < num_clear_port_p; p++) begin
            if (sb.clear_i[p]) begin
                w_clear_comb[sb.clear_id_i[p]] = 1'b1;
            end
        end
    end

    // A register retiring this cycle is already forwarded, so it never stalls.
    assign w_sb_hit        = |(w_rw_mask & r_sb & ~w_clear_comb);
    assign w_score_overlap = |(w_rw_mask & w_score_mask_raw);
    assign w_score_hit     = sb.score_i & w_score_overlap;
    assign sb.dependency_o = w_sb_hit | w_score_hit;

    assign w_sb_next = w_score_mask | (r_sb & ~w_clear_comb);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < els_p; i++) begin
            w_count = w_count + {{(cnt_width_lp-1){1'b0}}, r_sb[i]};
        end
    end

    assign sb.pending_count_o = w_count;
    assign sb.empty_o         = (r_sb == '0);

    a_score_clear_disjoint : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (w_score_mask & w_clear_comb) == '0
    );

    for (genvar p = 0; p < num_clear_port_p; p++) begin : g_clear_chk_p
        for (genvar q = p + 1; q < num_clear_port_p; q++) begin : g_clear_chk_q
            a_clear_ids_distinct : assert property (
                @(posedge clk_i) disable iff (!reset_n_i)
                !(sb.clear_i[p] && sb.clear_i[q] && (sb.clear_id_i[p] == sb.clear_id_i[q]))
            );
        end
    end

endmodule

// File: tb/tb_group_scoreboard.sv
// Directed scoreboard-style bench for group_scoreboard: 32 registers, 2 source
// ports, 2 clear ports, groups of 4, x0 tied to zero.
module tb_group_scoreboard;
    import group_scoreboard_pkg::*;

    localparam int ELS   = 32;
    localparam int NSRC  = 2;
    localparam int NCLR  = 2;
    localparam int W     = 8;

    logic clk;
    logic reset_n;

    group_scoreboard_if #(
        .els_p            (ELS),
        .num_src_port_p   (NSRC),
        .num_clear_port_p (NCLR)
    ) sb_if ();

    group_scoreboard #(
        .els_p             (ELS),
        .num_src_port_p    (NSRC),
        .num_clear_port_p  (NCLR),
        .group_els_p       (4),
        .x0_tied_to_zero_p (1'b1)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .sb        (sb_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         chk_v   = 1'b0;
    logic         chk_end = 1'b0;
    logic         mon_done = 1'b0;
    int           n_vec   = 0;
    int           n_miss  = 0;

    // ---------------- driver tasks ----------------
    task automatic idle();
        sb_if.src_id_i       = '0;
        sb_if.src_group_i    = '0;
        sb_if.op_reads_rf_i  = '0;
        sb_if.dest_id_i      = '0;
        sb_if.dest_group_i   = 1'b0;
        sb_if.op_writes_rf_i = 1'b0;
        sb_if.score_i        = 1'b0;
        sb_if.score_id_i     = '0;
        sb_if.score_group_i  = 1'b0;
        sb_if.clear_i        = '0;
        sb_if.clear_id_i     = '0;
    endtask

    task automatic rd(input int port, input int id, input bit grp);
        sb_if.src_id_i[port]      = 5'(id);
        sb_if.src_group_i[port]   = grp;
        sb_if.op_reads_rf_i[port] = 1'b1;
    endtask

    task automatic wr(input int id, input bit grp);
        sb_if.dest_id_i      = 5'(id);
        sb_if.dest_group_i   = grp;
        sb_if.op_writes_rf_i = 1'b1;
    endtask

    task automatic sc(input int id, input bit grp);
        sb_if.score_i       = 1'b1;
        sb_if.score_id_i    = 5'(id);
        sb_if.score_group_i = grp;
    endtask

    task automatic clr(input int port, input int id);
        sb_if.clear_i[port]    = 1'b1;
        sb_if.clear_id_i[port] = 5'(id);
    endtask

    // Expected value is this cycle's combinational view, before the next edge.
    task automatic step(input string name, input bit dep, input int cnt, input bit emp);
        exp_q.push_back({dep, 6'(cnt), emp});
        name_q.push_back(name);
        chk_v = 1'b1;
        @(posedge clk);
        #1;
        chk_v = 1'b0;
        idle();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        string        nm;
        forever begin
            @(negedge clk);
            if (chk_v) begin
                got_v = {sb_if.dependency_o, sb_if.pending_count_o, sb_if.empty_o};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL no_expected: got dep=%0d cnt=%0d empty=%0d with empty queue",
                             got_v[7], got_v[6:1], got_v[0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    nm    = name_q.pop_front();
                    if (got_v !== exp_v) begin
                        n_miss++;
                        $display("FAIL %s: got dep=%0d cnt=%0d empty=%0d, expected dep=%0d cnt=%0d empty=%0d",
                                 nm, got_v[7], got_v[6:1], got_v[0], exp_v[7], exp_v[6:1], exp_v[0]);
                    end
                end
            end
            if (chk_end && !mon_done) begin
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_miss++;
                    $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        idle();
        sc(5, 0);
        @(posedge clk);
        #1;

        sc(5, 0);                                 step("rst_hold_a", 0, 0, 1);
        sc(5, 0);                                 step("rst_hold_b", 0, 0, 1);
        reset_n = 1'b1;
        sc(5, 0);                                 step("score5", 0, 0, 1);
        rd(0, 5, 0);                              step("raw5", 1, 1, 0);
        clr(0, 5); rd(0, 5, 0);                   step("clr5_bypass", 0, 1, 0);
                                                  step("after_clr5", 0, 0, 1);

        sc(8, 1);                                 step("score_g8", 0, 0, 1);
        rd(0, 10, 0);                             step("rd10", 1, 4, 0);
        rd(1, 6, 1);                              step("rd_g6", 1, 4, 0);
        rd(0, 12, 0);                             step("rd12", 0, 4, 0);
        wr(12, 1);                                step("wr_g12", 0, 4, 0);
        wr(11, 0);                                step("wr11", 1, 4, 0);

        clr(0, 8); clr(1, 9); rd(0, 9, 0);        step("clr8_9", 0, 4, 0);
        clr(0, 10); clr(1, 11); rd(1, 10, 1);     step("clr10_11", 0, 2, 0);
                                                  step("after_mclr", 0, 0, 1);

        sc(30, 1);                                step("score_g30", 0, 0, 1);
                                                  step("cnt_wrap", 0, 3, 0);
        wr(31, 1);                                step("wr_g31", 1, 3, 0);
        rd(0, 0, 0);                              step("rd0", 0, 3, 0);
        rd(0, 1, 0);                              step("rd1", 1, 3, 0);
        clr(0, 30); clr(1, 31);                   step("clr30_31", 0, 3, 0);
        clr(0, 1);                                step("clr1", 0, 1, 0);

        sc(0, 0); rd(0, 0, 0);                    step("score_x0", 0, 0, 1);
                                                  step("after_x0", 0, 0, 1);

        rd(0, 7, 0);                              step("rd7_noscore", 0, 0, 1);
        sc(7, 0); rd(0, 7, 0);                    step("score7_rd7", 1, 0, 1);
                                                  step("cnt7", 0, 1, 0);
        sc(20, 0); clr(0, 7); rd(0, 7, 0);        step("score20_clr7", 0, 1, 0);
        rd(0, 20, 0);                             step("rd20", 1, 1, 0);

        reset_n = 1'b0;
        clr(0, 20); rd(0, 20, 0);                 step("rst_mid", 0, 0, 1);
        reset_n = 1'b1;                           step("rst_release", 0, 0, 1);

        chk_end = 1'b1;
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
